// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared definitions for the MIPS-lite write-back stage.
//   - datapath / register-file / counter widths
//   - opcode encodings and the instruction-class enum
//   - wb_fwd_t: the WB forwarding bundle {valid, rd, data}
//   - op_class(): opcode -> retired-instruction class
// The hazard unit and the EX forwarding mux reuse these types.
package wb_stage_pkg;

  localparam int DATA       = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 32;

  typedef enum logic [5:0] {
    OP_ADD  = 6'h00,
    OP_ADDI = 6'h01,
    OP_SUB  = 6'h02,
    OP_SUBI = 6'h03,
    OP_MUL  = 6'h04,
    OP_MULI = 6'h05,
    OP_OR   = 6'h06,
    OP_ORI  = 6'h07,
    OP_AND  = 6'h08,
    OP_ANDI = 6'h09,
    OP_XOR  = 6'h0A,
    OP_XORI = 6'h0B,
    OP_LDW  = 6'h0C,
    OP_STW  = 6'h0D,
    OP_BZ   = 6'h0E,
    OP_BEQ  = 6'h0F,
    OP_JR   = 6'h10,
    OP_HALT = 6'h11
  } opcode_e;

  typedef enum logic [2:0] {
    CLS_ARITH,
    CLS_LOGIC,
    CLS_MEM,
    CLS_CTRL,
    CLS_NONE
  } op_class_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA-1:0]       data;
  } wb_fwd_t;

  // Unknown opcodes map to CLS_NONE so they only reach the total counter.
  function automatic op_class_e op_class(input logic [5:0] op);
    op_class_e cls;
    case (op)
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_MULI: cls = CLS_ARITH;
      OP_OR, OP_ORI, OP_AND, OP_ANDI, OP_XOR, OP_XORI:   cls = CLS_LOGIC;
      OP_LDW, OP_STW:                                    cls = CLS_MEM;
      OP_BZ, OP_BEQ, OP_JR, OP_HALT:                     cls = CLS_CTRL;
      default:                                           cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/wb_stage_regfile_2r1w.sv
// regfile_2r1w: architectural register file, 2 combinational read ports,
// 1 synchronous write port. R0 is hardwired to zero.
//   clk, rst            clock, synchronous active-high reset (clears all regs)
//   we, waddr, wdata    write port (writes to R0 are dropped)
//   raddr_a/b, rdata_a/b read ports
// Optional macro WB_BYPASS_EN: a read of the register being written this
// cycle returns the write data (write-through) instead of the stored value.
module regfile_2r1w #(
  parameter int DATA       = 32,
  parameter int REG_COUNT  = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA-1:0]       wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA-1:0]       rdata_a,
  output logic [DATA-1:0]       rdata_b
);

  logic [DATA-1:0] regs [REG_COUNT];

  // NOTE: the register file is architectural state that must read 0 after
  // reset, so it is cleared explicitly; this keeps it out of RAM macros.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  function automatic logic [DATA-1:0] read_port(input logic [REG_ADDR_W-1:0] addr);
    logic [DATA-1:0] val;
    val = '0;
    if (addr != '0) begin
`ifdef WB_BYPASS_EN
      if (we && addr == waddr) val = wdata;
      else                     val = regs[addr];
`else
      val = regs[addr];
`endif
    end
    return val;
  endfunction

  // NOTE: read ports are pure combinational functions of their inputs; each
  // output is assigned on every path so no latch is inferred.
  always_comb begin
    rdata_a = read_port(raddr_a);
    rdata_b = read_port(raddr_b);
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the 5-stage MIPS-lite pipeline.
// Holds the MEM/WB latch, the register file, per-class retire counters and
// the RUN/HALTED FSM. A latched valid instruction writes back and retires on
// the posedge after it was captured; once HALT retires the stage freezes.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   valid_i, opcode_i, rd_i,          instruction from the MEM stage
//   reg_write_i, mem_to_reg_i,
//   alu_result_i, mem_data_i
//   rs_addr_i/rt_addr_i -> rs_data_o/rt_data_o   decode read ports
//   fwd_valid_o, fwd_rd_o, fwd_data_o            WB->EX forwarding entry
//   halted_o                                     HALT has retired
//   cnt_arith_o, cnt_logic_o, cnt_mem_o,
//   cnt_ctrl_o, cnt_total_o                      saturating retire counters
// Optional macro WB_BYPASS_EN: read ports see the value being written back
// in the same cycle (implemented inside regfile_2r1w).
module wb_stage #(
  parameter int DATA       = wb_stage_pkg::DATA,
  parameter int REG_COUNT  = wb_stage_pkg::REG_COUNT,
  parameter int REG_ADDR_W = wb_stage_pkg::REG_ADDR_W,
  parameter int CNT_W      = wb_stage_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [5:0]            opcode_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  reg_write_i,
  input  logic                  mem_to_reg_i,
  input  logic [DATA-1:0]       alu_result_i,
  input  logic [DATA-1:0]       mem_data_i,
  input  logic [REG_ADDR_W-1:0] rs_addr_i,
  input  logic [REG_ADDR_W-1:0] rt_addr_i,
  output logic [DATA-1:0]       rs_data_o,
  output logic [DATA-1:0]       rt_data_o,
  output logic                  fwd_valid_o,
  output logic [REG_ADDR_W-1:0] fwd_rd_o,
  output logic [DATA-1:0]       fwd_data_o,
  output logic                  halted_o,
  output logic [CNT_W-1:0]      cnt_arith_o,
  output logic [CNT_W-1:0]      cnt_logic_o,
  output logic [CNT_W-1:0]      cnt_mem_o,
  output logic [CNT_W-1:0]      cnt_ctrl_o,
  output logic [CNT_W-1:0]      cnt_total_o
);

  import wb_stage_pkg::*;

  typedef enum logic {ST_RUN, ST_HALTED} state_e;

  state_e state_q, state_d;
  logic   run;

  // MEM/WB latch
  logic                  lat_valid;
  logic [5:0]            lat_opcode;
  logic [REG_ADDR_W-1:0] lat_rd;
  logic                  lat_reg_write;
  logic [DATA-1:0]       lat_wb_val;

  logic [DATA-1:0] wb_val;
  logic            retire;
  op_class_e       cls;
  wb_fwd_t         fwd;

  logic [CNT_W-1:0] cnt_arith_q, cnt_logic_q, cnt_mem_q, cnt_ctrl_q, cnt_total_q;

  assign wb_val = mem_to_reg_i ? mem_data_i : alu_result_i;

  // ---------------- FSM ----------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    run      = 1'b0;
    halted_o = 1'b0;
    case (state_q)
      ST_RUN: begin
        run = 1'b1;
        if (lat_valid && lat_opcode == OP_HALT) state_d = ST_HALTED;
      end
      ST_HALTED: halted_o = 1'b1;
      default:   state_d = ST_RUN;
    endcase
  end

  // ---------------- MEM/WB latch ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_valid     <= 1'b0;
      lat_opcode    <= '0;
      lat_rd        <= '0;
      lat_reg_write <= 1'b0;
      lat_wb_val    <= '0;
    end else if (run) begin
      lat_valid     <= valid_i;
      lat_opcode    <= opcode_i;
      lat_rd        <= rd_i;
      lat_reg_write <= reg_write_i;
      lat_wb_val    <= wb_val;
    end
  end

  // The latched instruction retires (and writes back) on the next edge,
  // unless the stage is frozen.
  assign retire = run && lat_valid;
  assign cls    = op_class(lat_opcode);

  // ---------------- forwarding ----------------
  always_comb begin
    fwd.valid = retire && lat_reg_write && (lat_rd != '0);
    fwd.rd    = lat_rd;
    fwd.data  = lat_wb_val;
  end

  assign fwd_valid_o = fwd.valid;
  assign fwd_rd_o    = fwd.rd;
  assign fwd_data_o  = fwd.data;

  // ---------------- register file ----------------
  regfile_2r1w #(
    .DATA      (DATA),
    .REG_COUNT (REG_COUNT),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (fwd.valid),
    .waddr  (fwd.rd),
    .wdata  (fwd.data),
    .raddr_a(rs_addr_i),
    .raddr_b(rt_addr_i),
    .rdata_a(rs_data_o),
    .rdata_b(rt_data_o)
  );

  // ---------------- retire counters (saturating) ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_arith_q <= '0;
      cnt_logic_q <= '0;
      cnt_mem_q   <= '0;
      cnt_ctrl_q  <= '0;
      cnt_total_q <= '0;
    end else if (retire) begin
      if (cnt_total_q != '1) cnt_total_q <= cnt_total_q + CNT_W'(1);
      case (cls)
        CLS_ARITH: if (cnt_arith_q != '1) cnt_arith_q <= cnt_arith_q + CNT_W'(1);
        CLS_LOGIC: if (cnt_logic_q != '1) cnt_logic_q <= cnt_logic_q + CNT_W'(1);
        CLS_MEM:   if (cnt_mem_q   != '1) cnt_mem_q   <= cnt_mem_q   + CNT_W'(1);
        CLS_CTRL:  if (cnt_ctrl_q  != '1) cnt_ctrl_q  <= cnt_ctrl_q  + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign cnt_arith_o = cnt_arith_q;
  assign cnt_logic_o = cnt_logic_q;
  assign cnt_mem_o   = cnt_mem_q;
  assign cnt_ctrl_o  = cnt_ctrl_q;
  assign cnt_total_o = cnt_total_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage (counters built
// 4 bits wide so saturation is reachable). Expected values are hand-derived.
// Compile with or without WB_BYPASS_EN; the bypass expectation follows it.
module tb_wb_stage;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [5:0]  opcode_i;
  logic [4:0]  rd_i;
  logic        reg_write_i;
  logic        mem_to_reg_i;
  logic [31:0] alu_result_i;
  logic [31:0] mem_data_i;
  logic [4:0]  rs_addr_i;
  logic [4:0]  rt_addr_i;
  logic [31:0] rs_data_o;
  logic [31:0] rt_data_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_rd_o;
  logic [31:0] fwd_data_o;
  logic        halted_o;
  logic [CW-1:0] cnt_arith_o, cnt_logic_o, cnt_mem_o, cnt_ctrl_o, cnt_total_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .opcode_i    (opcode_i),
    .rd_i        (rd_i),
    .reg_write_i (reg_write_i),
    .mem_to_reg_i(mem_to_reg_i),
    .alu_result_i(alu_result_i),
    .mem_data_i  (mem_data_i),
    .rs_addr_i   (rs_addr_i),
    .rt_addr_i   (rt_addr_i),
    .rs_data_o   (rs_data_o),
    .rt_data_o   (rt_data_o),
    .fwd_valid_o (fwd_valid_o),
    .fwd_rd_o    (fwd_rd_o),
    .fwd_data_o  (fwd_data_o),
    .halted_o    (halted_o),
    .cnt_arith_o (cnt_arith_o),
    .cnt_logic_o (cnt_logic_o),
    .cnt_mem_o   (cnt_mem_o),
    .cnt_ctrl_o  (cnt_ctrl_o),
    .cnt_total_o (cnt_total_o)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic rw,
                       input logic m2r, input logic [31:0] alu, input logic [31:0] mem);
    valid_i      = 1'b1;
    opcode_i     = op;
    rd_i         = rd;
    reg_write_i  = rw;
    mem_to_reg_i = m2r;
    alu_result_i = alu;
    mem_data_i   = mem;
  endtask

  task automatic idle();
    valid_i      = 1'b0;
    opcode_i     = 6'h3F;
    rd_i         = 5'd0;
    reg_write_i  = 1'b0;
    mem_to_reg_i = 1'b0;
    alu_result_i = 32'h0;
    mem_data_i   = 32'h0;
  endtask

  task automatic check_counters(input string tag, input logic [CW-1:0] ar, input logic [CW-1:0] lo,
                                input logic [CW-1:0] me, input logic [CW-1:0] ct, input logic [CW-1:0] to);
    check({tag, " arith"}, 32'(cnt_arith_o), 32'(ar));
    check({tag, " logic"}, 32'(cnt_logic_o), 32'(lo));
    check({tag, " mem"},   32'(cnt_mem_o),   32'(me));
    check({tag, " ctrl"},  32'(cnt_ctrl_o),  32'(ct));
    check({tag, " total"}, 32'(cnt_total_o), 32'(to));
  endtask

  initial begin
    idle();
    rs_addr_i = 5'd0;
    rt_addr_i = 5'd0;

    // ---- reset ----
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs_addr_i = 5'(i);
      rt_addr_i = 5'(31 - i);
      #1;
      check("reset rs", rs_data_o, 32'h0);
      check("reset rt", rt_data_o, 32'h0);
    end
    check("reset halted", 32'(halted_o), 32'h0);
    check("reset fwd_valid", 32'(fwd_valid_o), 32'h0);
    check("reset fwd_rd", 32'(fwd_rd_o), 32'h0);
    check("reset fwd_data", fwd_data_o, 32'h0);
    check_counters("reset", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

    // ---- ADDI R5 <- 0x2A ----
    rs_addr_i = 5'd0;
    rt_addr_i = 5'd0;
    drive(6'h01, 5'd5, 1'b1, 1'b0, 32'h0000_002A, 32'h0000_1234);
    tick();
    idle();
    check("addi fwd_valid", 32'(fwd_valid_o), 32'h1);
    check("addi fwd_rd", 32'(fwd_rd_o), 32'd5);
    check("addi fwd_data", fwd_data_o, 32'h2A);
    check("addi total before wb", 32'(cnt_total_o), 32'h0);
    tick();
    rs_addr_i = 5'd5;
    #1;
    check("addi R5", rs_data_o, 32'h2A);
    check("addi fwd_valid after", 32'(fwd_valid_o), 32'h0);
    check_counters("addi", 4'd1, 4'd0, 4'd0, 4'd0, 4'd1);

    // ---- LDW R7 <- mem data ----
    drive(6'h0C, 5'd7, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    tick();
    idle();
    check("ldw fwd_data", fwd_data_o, 32'hDEAD_BEEF);
    tick();
    rt_addr_i = 5'd7;
    #1;
    check("ldw R7", rt_data_o, 32'hDEAD_BEEF);
    check_counters("ldw", 4'd1, 4'd0, 4'd1, 4'd0, 4'd2);

    // ---- ADD to R0 is discarded ----
    drive(6'h00, 5'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
    tick();
    idle();
    check("r0 fwd_valid", 32'(fwd_valid_o), 32'h0);
    tick();
    rs_addr_i = 5'd0;
    #1;
    check("r0 read", rs_data_o, 32'h0);
    check_counters("r0", 4'd2, 4'd0, 4'd1, 4'd0, 4'd3);

    // ---- OR R9 <- 0x55 : bypass window ----
    drive(6'h06, 5'd9, 1'b1, 1'b0, 32'h0000_0055, 32'h0);
    tick();
    idle();
    rs_addr_i = 5'd9;
    #1;
`ifdef WB_BYPASS_EN
    check("bypass R9", rs_data_o, 32'h55);
`else
    check("no-bypass R9", rs_data_o, 32'h0);
`endif
    tick();
    check("R9 after wb", rs_data_o, 32'h55);
    check_counters("or", 4'd2, 4'd1, 4'd1, 4'd0, 4'd4);

    // ---- STW (no reg write), unknown opcode, BZ, BEQ back-to-back ----
    drive(6'h0D, 5'd4, 1'b0, 1'b0, 32'h0000_0044, 32'h0);
    tick();
    check("stw fwd_valid", 32'(fwd_valid_o), 32'h0);
    drive(6'h3F, 5'd6, 1'b1, 1'b0, 32'h0000_0077, 32'h0);
    tick();
    check("unk fwd_valid", 32'(fwd_valid_o), 32'h1);
    drive(6'h0E, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    drive(6'h0F, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    idle();
    tick();
    rs_addr_i = 5'd4;
    rt_addr_i = 5'd6;
    #1;
    check("stw R4 untouched", rs_data_o, 32'h0);
    check("unk R6", rt_data_o, 32'h77);
    check_counters("mix", 4'd2, 4'd1, 4'd2, 4'd2, 4'd8);

    // ---- HALT, then ADD R3 while halted ----
    drive(6'h11, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("halt latched, not yet halted", 32'(halted_o), 32'h0);
    drive(6'h00, 5'd3, 1'b1, 1'b0, 32'h0000_0033, 32'h0);
    tick();
    check("halted", 32'(halted_o), 32'h1);
    check("halted fwd_valid", 32'(fwd_valid_o), 32'h0);
    tick();
    tick();
    tick();
    idle();
    rs_addr_i = 5'd3;
    rt_addr_i = 5'd9;
    #1;
    check("halted R3 unchanged", rs_data_o, 32'h0);
    check("halted read R9", rt_data_o, 32'h55);
    check("still halted", 32'(halted_o), 32'h1);
    check_counters("halt", 4'd2, 4'd1, 4'd2, 4'd3, 4'd9);

    // ---- reset out of HALTED ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rs_addr_i = 5'd5;
    rt_addr_i = 5'd9;
    #1;
    check("rst halted", 32'(halted_o), 32'h0);
    check("rst R5", rs_data_o, 32'h0);
    check("rst R9", rt_data_o, 32'h0);
    check("rst fwd_valid", 32'(fwd_valid_o), 32'h0);
    check_counters("rst", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

    // ---- saturation: 15 ADDs, then one more ----
    for (int i = 1; i <= 15; i++) begin
      drive(6'h00, 5'd1, 1'b1, 1'b0, 32'(i), 32'h0);
      tick();
    end
    idle();
    tick();
    rs_addr_i = 5'd1;
    #1;
    check("sat R1", rs_data_o, 32'd15);
    check_counters("sat15", 4'hF, 4'd0, 4'd0, 4'd0, 4'hF);
    drive(6'h00, 5'd1, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    tick();
    idle();
    tick();
    check("sat16 R1", rs_data_o, 32'h100);
    check_counters("sat16", 4'hF, 4'd0, 4'd0, 4'd0, 4'hF);
    check("sat16 halted", 32'(halted_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 5-stage MIPS-lite pipeline; sits directly downstream of the memory-access stage.
- Holds the MEM/WB pipeline register and the 32-entry architectural register file; selects ALU result or load data for write-back.
- Serves the decode-stage read ports and the WB-to-EX forwarding path.
- Keeps retired-instruction counters per class and detects HALT to freeze the machine.

Parameters:
DATA, 32, datapath/register width
REG_COUNT, 32, architectural registers (R0 hardwired to 0)
REG_ADDR_W, 5, register index width
CNT_W, 32, retired-counter width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
valid_i  in  1  MEM stage presents a valid instruction this cycle
opcode_i  in  6  opcode of that instruction
rd_i  in  REG_ADDR_W  destination register
reg_write_i  in  1  instruction writes the register file
mem_to_reg_i  in  1  1 = write load data, 0 = write ALU result
alu_result_i  in  DATA  write-back data from MEM stage
mem_data_i  in  DATA  load data from MEM stage
rs_addr_i  in  REG_ADDR_W  decode read port A address
rt_addr_i  in  REG_ADDR_W  decode read port B address
rs_data_o  out  DATA  read port A data
rt_data_o  out  DATA  read port B data
fwd_valid_o  out  1  WB forwarding entry valid
fwd_rd_o  out  REG_ADDR_W  WB forwarding destination
fwd_data_o  out  DATA  WB forwarding value
halted_o  out  1  HALT has retired; pipeline must freeze
cnt_arith_o  out  CNT_W  retired ADD/ADDI/SUB/SUBI/MUL/MULI
cnt_logic_o  out  CNT_W  retired OR/ORI/AND/ANDI/XOR/XORI
cnt_mem_o  out  CNT_W  retired LDW/STW
cnt_ctrl_o  out  CNT_W  retired BZ/BEQ/JR/HALT
cnt_total_o  out  CNT_W  all retired instructions

Behaviour:
- Reset (rst high at posedge): MEM/WB latch valid=0; all registers 0; all counters 0; FSM=RUN. Outputs after reset: halted_o=0, fwd_valid_o=0, fwd_rd_o=0, fwd_data_o=0, counters 0. rs/rt_data_o read 0.
- Reset mid-operation, including while HALTED: full clear; FSM returns to RUN.
- Latch: each posedge in RUN captures valid_i, opcode_i, rd_i, reg_write_i and wb_val. wb_val = mem_to_reg_i ? mem_data_i : alu_result_i. One cycle MEM->WB latency.
- Register write: at the posedge after latching, if latch valid && reg_write && rd!=0, then reg[rd] <= wb_val.
- R0: writes to rd=0 are discarded. Reads of R0 always return 0.
- Forwarding outputs: fwd_valid_o = latch valid && reg_write && rd!=0. fwd_rd_o and fwd_data_o are taken from the latch. Outputs are combinational from the latch.
- Read ports: combinational from the register file, plus the bypass described under Optional Feature.
- Retire/counters: each latched valid instruction increments cnt_total_o and exactly one class counter on the cycle it writes back.
- Counter saturation: counters saturate at all-ones and never wrap.
- Unknown opcodes: counted in total only.
- FSM RUN -> HALTED: when the latched valid opcode is HALT (6'b010001). The HALT itself is counted.
- HALTED state: halted_o=1; the latch no longer captures (valid_i ignored); no register writes, no counter updates; fwd_valid_o=0. Read ports remain functional.
- Opcode encodings (ADD=0x00 ... JR=0x10, HALT=0x11) are defined in the shared package.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined: if a read address equals the latched rd and a write is pending this cycle (fwd_valid_o), the read port returns wb_val (write-through). Decode sees the value in the same cycle it is written.
- When undefined: read ports return the stored register only. Decode must stall one extra cycle on such a hazard.

Decomposition:
- Package: opcode enum, instruction-class enum, REG_ADDR_W, CNT_W, and a WbFwd struct {valid, rd, data}. All are reused by the hazard unit and EX forwarding mux.
- Sub-module regfile_2r1w: 2 read ports, 1 write port, R0 hardwired, with the optional bypass inside it.
- wb_stage contains the latch, FSM, counters and class decode.

Test Plan:
- Reset: drive rst for 2 cycles, then read all regs -> rs/rt_data_o=0, halted_o=0, all counters 0.
- ADDI to R5 with alu_result_i=0x0000_002A, reg_write=1 -> next cycle fwd_valid_o=1, fwd_rd_o=5, fwd_data_o=0x2A. Following cycle reading R5 gives 0x2A; cnt_arith_o=1, cnt_total_o=1.
- LDW to R7, mem_to_reg=1, mem_data_i=0xDEAD_BEEF, alu_result_i=0x100 -> R7=0xDEADBEEF; cnt_mem_o=1. Write to rd=0 with 0xFFFF_FFFF -> R0 reads 0, fwd_valid_o=0.
- Bypass: while the latch holds a write to R9 of 0x55, read rs_addr_i=9 -> 0x55 with WB_BYPASS_EN defined; the old value (0) without it.
- HALT, then drive ADD to R3 on valid_i -> halted_o=1 the cycle after HALT latches; R3 unchanged; cnt_ctrl_o=1, cnt_total_o frozen. Assert rst -> halted_o=0, counters 0.
- Saturation: force cnt_total_o to all-ones via 2^CNT_W-1 retires (bench with CNT_W=4: 15 ADDs), then 1 more ADD -> stays 4'hF.
